des_key_schedule_seq: RTL

Sequential, parametrised DES/3DES round-key generator. It latches one or three 56-bit post-PC1 keys and streams the 48-bit PC2 round keys one per accepted transfer over a valid/ready handshake. For 3DES it covers the full EDE pass sequence. It sits between the key-exchange output stage and a single-round iterative DES core, and replaces the all-16-keys-in-parallel combinational generator with a rotating C/D register pair.

---
 rtl/des_key_schedule_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/des_key_schedule_seq.sv
// Sequential DES/3DES round-key generator: rotating C/D register pair feeding PC2,
// one round key per valid/ready transfer. States: IDLE | waiting for start, RUN | streaming keys.
module des_key_schedule_seq #(
    parameter int NUM_PASSES = 3,
    parameter int ROUNDS     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        is_encrypt,
    input  logic [0:NUM_PASSES-1][0:55] key_in,
    input  logic                        abort,
    output logic                        busy,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [0:47]                 round_key,
    output logic [3:0]                  round_idx,
    output logic [1:0]                  pass_idx,
    output logic                        done
);

    if (!(NUM_PASSES == 1 || NUM_PASSES == 3) || ROUNDS != 16) begin : g_bad_param
        $error("des_key_schedule_seq: NUM_PASSES must be 1 or 3 and ROUNDS must be 16");
    end

    localparam int         KW        = NUM_PASSES * 56;
    localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

    // PC2 source positions, 1-based from the MSB of the 56-bit C/D word
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [55:0]     cd_q, cd_d;
    logic [KW-1:0]   keys_q, keys_d;
    logic            enc_q, enc_d;
    logic [3:0]      round_q, round_d;
    logic [1:0]      pass_q, pass_d;
    logic            done_q, done_d;
    logic            one_shift;

    // C occupies cd[55:28] and D cd[27:0]; MSB of each half is the spec's bit 0
    function automatic logic [55:0] rot_l(input logic [55:0] cd, input logic one);
        if (one) return {cd[54:28], cd[55], cd[26:0], cd[27]};
        return {cd[53:28], cd[55:54], cd[25:0], cd[27:26]};
    endfunction

    function automatic logic [55:0] rot_r(input logic [55:0] cd, input logic one);
        if (one) return {cd[28], cd[55:29], cd[0], cd[27:1]};
        return {cd[29:28], cd[55:30], cd[1:0], cd[27:2]};
    endfunction

    // 3DES EDE: encrypt walks K1,K2,K3 as E,D,E; decrypt walks K3,K2,K1 as D,E,D
    function automatic logic [55:0] pass_key(input logic [KW-1:0] keys, input logic enc,
                                             input logic [1:0] p);
        logic [1:0] idx;
        int         lsb;
        if (NUM_PASSES == 1) idx = 2'd0;
        else                 idx = enc ? p : 2'd2 - p;
        lsb = KW - 56 * (int'(idx) + 1);
        return keys[lsb +: 56];
    endfunction

    function automatic logic pass_dir(input logic enc, input logic [1:0] p);
        if (NUM_PASSES == 1) return enc;
        return enc ^ (p == 2'd1);
    endfunction

    function automatic logic [55:0] first_cd(input logic [55:0] key, input logic dir);
        return dir ? rot_l(key, 1'b1) : key;
    endfunction

    // Encrypt step into round r+2 and decrypt step into round r+2 both use a
    // single-bit shift exactly when the current round index is 0, 7 or 14.
    assign one_shift = round_q inside {4'd0, 4'd7, 4'd14};

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        keys_d  = keys_q;
        enc_d   = enc_q;
        round_d = round_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    enc_d   = is_encrypt;
                    keys_d  = key_in;
                    round_d = 4'd0;
                    pass_d  = 2'd0;
                    cd_d    = first_cd(pass_key(key_in, is_encrypt, 2'd0),
                                       pass_dir(is_encrypt, 2'd0));
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    round_d = 4'd0;
                    pass_d  = 2'd0;
                    cd_d    = '0;
                end else if (key_ready) begin
                    if (round_q == 4'd15) begin
                        if (pass_q == LAST_PASS) begin
                            state_d = IDLE;
                            round_d = 4'd0;
                            pass_d  = 2'd0;
                            cd_d    = '0;
                            done_d  = 1'b1;
                        end else begin
                            pass_d  = pass_q + 2'd1;
                            round_d = 4'd0;
                            cd_d    = first_cd(pass_key(keys_q, enc_q, pass_q + 2'd1),
                                               pass_dir(enc_q, pass_q + 2'd1));
                        end
                    end else begin
                        round_d = round_q + 4'd1;
                        cd_d    = pass_dir(enc_q, pass_q) ? rot_l(cd_q, one_shift)
                                                          : rot_r(cd_q, one_shift);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            keys_q  <= '0;
            enc_q   <= 1'b0;
            round_q <= 4'd0;
            pass_q  <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            keys_q  <= keys_d;
            enc_q   <= enc_d;
            round_q <= round_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        round_key = '0;
        for (int i = 0; i < 48; i++) begin
            round_key[i] = cd_q[56 - PC2_TAB[i]];
        end
    end

    assign busy      = (state_q == RUN);
    assign key_valid = busy;
    assign round_idx = round_q;
    assign pass_idx  = pass_q;
    assign done      = done_q;

endmodule
